// File: rtl/mcy_mutsel_ctrl.sv
// Multi-channel MCY mutation-select controller: arms per-channel
// mutsel indices and tracks golden-vs-mutant divergence statistics.
module mcy_mutsel_ctrl #(
  parameter int NUM_CH   = 4,
  parameter int MUTSEL_W = 8,
  parameter int CMP_W    = 32,
  parameter int DELAY_W  = 16,
  parameter int CNT_W    = 16,
  parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_valid_i,
  output logic                       cfg_ready_o,
  input  logic [CH_W-1:0]            cfg_ch_i,
  input  logic [MUTSEL_W-1:0]        cfg_idx_i,
  input  logic [DELAY_W-1:0]         cfg_delay_i,
  input  logic [NUM_CH-1:0]          clear_i,
  output logic [NUM_CH*MUTSEL_W-1:0] mutsel_o,
  input  logic [NUM_CH-1:0]          cmp_valid_i,
  input  logic [NUM_CH*CMP_W-1:0]    golden_i,
  input  logic [NUM_CH*CMP_W-1:0]    mutant_i,
  output logic [NUM_CH-1:0]          active_o,
  output logic [NUM_CH-1:0]          detected_o,
  output logic [NUM_CH*CNT_W-1:0]    div_cnt_o,
  output logic [NUM_CH*CNT_W-1:0]    first_div_o
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ARMING   = 2'd1;
  localparam logic [1:0] ACTIVE   = 2'd2;
  localparam logic [1:0] DETECTED = 2'd3;

  logic [NUM_CH-1:0] acc;

  // Out-of-range channel numbers match no slot, so ready stays low.
  assign cfg_ready_o = rst_n & (|acc);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [1:0]          state;
    logic [MUTSEL_W-1:0] idx;
    logic [DELAY_W-1:0]  dly;
    logic [CNT_W-1:0]    cyc;
    logic [CNT_W-1:0]    dcnt;
    logic [CNT_W-1:0]    fdiv;
    logic                live;
    logic                hit;
    logic                div;

    assign live = (state == ACTIVE) ||
                  (state == DETECTED);
    assign hit  = cfg_valid_i &&
                  (cfg_ch_i == CH_W'(c));
    assign acc[c] = hit && (state == IDLE) &&
                    !clear_i[c];
    assign div  = cmp_valid_i[c] && live &&
                  (golden_i[c*CMP_W +: CMP_W] !=
                   mutant_i[c*CMP_W +: CMP_W]);

    assign mutsel_o[c*MUTSEL_W +: MUTSEL_W] =
      (rst_n && live) ? idx : '0;
    assign active_o[c]   = rst_n && live;
    assign detected_o[c] = rst_n &&
                           (state == DETECTED);
    assign div_cnt_o[c*CNT_W +: CNT_W]   = dcnt;
    assign first_div_o[c*CNT_W +: CNT_W] = fdiv;

    always_ff @(posedge clk) begin
      if (!rst_n || clear_i[c]) begin
        state <= IDLE;
        idx   <= '0;
        dly   <= '0;
        cyc   <= '0;
        dcnt  <= '0;
        fdiv  <= '0;
      end else if (acc[c]) begin
        idx   <= cfg_idx_i;
        dly   <= cfg_delay_i;
        cyc   <= '0;
        dcnt  <= '0;
        fdiv  <= '0;
        state <= (cfg_delay_i == '0) ?
                 ACTIVE : ARMING;
      end else begin
        unique case (1'b1)
          (state == ARMING): begin
            if (dly == DELAY_W'(1)) state <= ACTIVE;
            dly <= dly - 1'b1;
          end
          live: begin
            if (cyc != '1) cyc <= cyc + 1'b1;
            if (div) begin
              if (dcnt != '1) dcnt <= dcnt + 1'b1;
              // First divergence records pre-increment cycle.
              if (state == ACTIVE) begin
                fdiv  <= cyc;
                state <= DETECTED;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mcy_mutsel_ctrl.sv
// Self-checking bench for mcy_mutsel_ctrl: vector table, directed
// corner sequences and random traffic against a behavioural model.
module tb_mcy_mutsel_ctrl;

  localparam int NCH = 4;
  localparam int MW  = 8;
  localparam int CW  = 8;
  localparam int DW  = 8;
  localparam int NW  = 4;
  localparam int MAXC = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [1:0]    cfg_ch;
  logic [MW-1:0] cfg_idx;
  logic [DW-1:0] cfg_delay;
  logic [3:0]    clear;
  logic [31:0]   mutsel;
  logic [3:0]    cmp_valid;
  logic [31:0]   golden;
  logic [31:0]   mutant;
  logic [3:0]    active;
  logic [3:0]    detected;
  logic [15:0]   div_cnt;
  logic [15:0]   first_div;

  int checks = 0;
  int errors = 0;

  bit m_busy [NCH];
  int m_arm  [NCH];
  int m_idx  [NCH];
  int m_cyc  [NCH];
  int m_div  [NCH];
  int m_first[NCH];
  bit m_det  [NCH];

  always #5 clk = ~clk;

  mcy_mutsel_ctrl #(
    .NUM_CH(NCH), .MUTSEL_W(MW), .CMP_W(CW),
    .DELAY_W(DW), .CNT_W(NW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cfg_valid_i(cfg_valid),
    .cfg_ready_o(cfg_ready),
    .cfg_ch_i(cfg_ch),
    .cfg_idx_i(cfg_idx),
    .cfg_delay_i(cfg_delay),
    .clear_i(clear),
    .mutsel_o(mutsel),
    .cmp_valid_i(cmp_valid),
    .golden_i(golden),
    .mutant_i(mutant),
    .active_o(active),
    .detected_o(detected),
    .div_cnt_o(div_cnt),
    .first_div_o(first_div)
  );

  task automatic chk(string n, logic [63:0] a,
                     logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               n, a, e);
    end
  endtask

  function automatic bit exp_ready();
    if (!rst_n || !cfg_valid) return 1'b0;
    if (int'(cfg_ch) >= NCH) return 1'b0;
    return !m_busy[cfg_ch] && !clear[cfg_ch];
  endfunction

  task automatic check_model();
    logic [31:0] em;
    logic [3:0]  ea, ed;
    logic [15:0] edc, efd;
    bit lv;
    for (int c = 0; c < NCH; c++) begin
      lv = m_busy[c] && (m_arm[c] == 0);
      em[c*MW +: MW] = (rst_n && lv) ?
                       MW'(m_idx[c]) : '0;
      ea[c] = rst_n && lv;
      ed[c] = rst_n && m_det[c];
      edc[c*NW +: NW] = NW'(m_div[c]);
      efd[c*NW +: NW] = NW'(m_first[c]);
    end
    chk("ready", 64'(cfg_ready), 64'(exp_ready()));
    chk("mutsel", 64'(mutsel), 64'(em));
    chk("active", 64'(active), 64'(ea));
    chk("detected", 64'(detected), 64'(ed));
    chk("div_cnt", 64'(div_cnt), 64'(edc));
    chk("first_div", 64'(first_div), 64'(efd));
  endtask

  task automatic model_edge();
    int a;
    a = exp_ready() ? int'(cfg_ch) : -1;
    for (int c = 0; c < NCH; c++) begin
      if (!rst_n || clear[c]) begin
        m_busy[c] = 0; m_arm[c] = 0; m_idx[c] = 0;
        m_cyc[c] = 0; m_div[c] = 0;
        m_first[c] = 0; m_det[c] = 0;
      end else if (a == c) begin
        m_busy[c] = 1;
        m_arm[c] = int'(cfg_delay);
        m_idx[c] = int'(cfg_idx);
        m_cyc[c] = 0; m_div[c] = 0;
        m_first[c] = 0; m_det[c] = 0;
      end else if (m_busy[c]) begin
        if (m_arm[c] > 0) m_arm[c]--;
        else begin
          if (cmp_valid[c] &&
              golden[c*CW +: CW] != mutant[c*CW +: CW])
          begin
            if (!m_det[c]) begin
              m_first[c] = m_cyc[c];
              m_det[c] = 1;
            end
            if (m_div[c] < MAXC) m_div[c]++;
          end
          if (m_cyc[c] < MAXC) m_cyc[c]++;
        end
      end
    end
  endtask

  task automatic tick();
    #1;
    check_model();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic req(bit v, int ch, int idx, int d);
    cfg_valid = v;
    cfg_ch = 2'(ch);
    cfg_idx = MW'(idx);
    cfg_delay = DW'(d);
  endtask

  // Mismatch (or not) on one channel, compare strobe on that channel.
  task automatic cmp(int ch, bit cv, bit mm);
    golden = $urandom;
    mutant = golden;
    cmp_valid = '0;
    cmp_valid[ch] = cv;
    if (mm) mutant[ch*CW] = ~golden[ch*CW];
  endtask

  typedef struct {
    bit       v;
    bit [7:0] idx;
    bit [7:0] dly;
    bit       clr;
    bit       cv;
    bit       mm;
    bit       er;
    bit [7:0] ems;
    bit [3:0] ediv;
    bit [3:0] efd;
    bit       edet;
  } vec_t;

  vec_t tbl[15];

  initial begin
    tbl[0]  = '{1, 8'h2A, 3, 0, 0, 0, 1, 8'h00, 0, 0, 0};
    tbl[1]  = '{0, 8'h2A, 3, 0, 1, 1, 0, 8'h00, 0, 0, 0};
    tbl[2]  = '{0, 8'h2A, 3, 0, 1, 1, 0, 8'h00, 0, 0, 0};
    tbl[3]  = '{0, 8'h2A, 3, 0, 1, 1, 0, 8'h00, 0, 0, 0};
    tbl[4]  = '{0, 8'h2A, 3, 0, 0, 1, 0, 8'h2A, 0, 0, 0};
    tbl[5]  = '{0, 8'h2A, 3, 0, 1, 0, 0, 8'h2A, 0, 0, 0};
    tbl[6]  = '{0, 8'h2A, 3, 0, 1, 1, 0, 8'h2A, 0, 0, 0};
    tbl[7]  = '{0, 8'h2A, 3, 0, 0, 0, 0, 8'h2A, 1, 2, 1};
    tbl[8]  = '{0, 8'h2A, 3, 1, 0, 0, 0, 8'h2A, 1, 2, 1};
    tbl[9]  = '{1, 8'h2A, 0, 0, 0, 0, 1, 8'h00, 0, 0, 0};
    tbl[10] = '{0, 8'h2A, 0, 0, 0, 0, 0, 8'h2A, 0, 0, 0};
    tbl[11] = '{1, 8'h55, 0, 0, 0, 0, 0, 8'h2A, 0, 0, 0};
    tbl[12] = '{1, 8'h55, 0, 1, 0, 0, 0, 8'h2A, 0, 0, 0};
    tbl[13] = '{1, 8'h55, 0, 0, 0, 0, 1, 8'h00, 0, 0, 0};
    tbl[14] = '{0, 8'h55, 0, 0, 0, 0, 0, 8'h55, 0, 0, 0};

    rst_n = 0;
    req(0, 0, 0, 0);
    clear = '0;
    cmp(0, 0, 0);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    tick();
    rst_n = 1;
    #1;
    chk("rst_mutsel", 64'(mutsel), 64'h0);
    chk("rst_divcnt", 64'(div_cnt), 64'h0);

    // Channel 0: arming latency, qualification, busy and clear.
    foreach (tbl[i]) begin
      req(tbl[i].v, 0, tbl[i].idx, tbl[i].dly);
      clear = {3'b0, tbl[i].clr};
      cmp(0, tbl[i].cv, tbl[i].mm);
      #1;
      chk($sformatf("t%0d_ready", i),
          64'(cfg_ready), 64'(tbl[i].er));
      chk($sformatf("t%0d_mutsel0", i),
          64'(mutsel[7:0]), 64'(tbl[i].ems));
      chk($sformatf("t%0d_div0", i),
          64'(div_cnt[3:0]), 64'(tbl[i].ediv));
      chk($sformatf("t%0d_first0", i),
          64'(first_div[3:0]), 64'(tbl[i].efd));
      chk($sformatf("t%0d_det0", i),
          64'(detected[0]), 64'(tbl[i].edet));
      tick();
    end
    req(0, 0, 0, 0);
    clear = '0;

    // Channel 2: detection at active cycle 5, then saturation.
    req(1, 2, 8'h77, 0);
    cmp(2, 0, 0);
    tick();
    req(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cmp(2, 1, 0);
      tick();
    end
    cmp(2, 1, 1);
    tick();
    cmp(2, 0, 0);
    #1;
    chk("det_flag2", 64'(detected[2]), 64'h1);
    chk("det_first2", 64'(first_div[11:8]), 64'h5);
    chk("det_div2", 64'(div_cnt[11:8]), 64'h1);
    for (int i = 0; i < 2; i++) begin
      cmp(2, 1, 1);
      tick();
    end
    cmp(2, 0, 0);
    #1;
    chk("det_div2_3", 64'(div_cnt[11:8]), 64'h3);
    chk("det_first2_5", 64'(first_div[11:8]), 64'h5);
    for (int i = 0; i < 20; i++) begin
      cmp(2, 1, 1);
      tick();
    end
    cmp(2, 0, 0);
    #1;
    chk("sat_div2", 64'(div_cnt[11:8]), 64'hF);

    clear = 4'b0100;
    tick();
    clear = '0;
    req(1, 2, 8'h77, 0);
    tick();
    req(0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      cmp(2, 0, 1);
      tick();
    end
    cmp(2, 1, 1);
    tick();
    cmp(2, 0, 0);
    #1;
    chk("sat_cyc2", 64'(first_div[11:8]), 64'hF);

    // Channel 3: stall on busy, clear blocks acceptance for one cycle.
    req(1, 3, 8'h33, 0);
    #1;
    chk("busy_acc3", 64'(cfg_ready), 64'h1);
    tick();
    cmp(3, 1, 1);
    tick();
    req(1, 3, 8'h44, 2);
    #1;
    chk("busy_stall3", 64'(cfg_ready), 64'h0);
    tick();
    clear = 4'b1000;
    #1;
    chk("clr_block3", 64'(cfg_ready), 64'h0);
    tick();
    clear = '0;
    #1;
    chk("clr_next3", 64'(cfg_ready), 64'h1);
    tick();
    req(0, 0, 0, 0);
    cmp(3, 0, 0);
    #1;
    chk("clr_div3", 64'(div_cnt[15:12]), 64'h0);
    chk("clr_arm3", 64'(mutsel[31:24]), 64'h0);
    tick();
    tick();
    #1;
    chk("clr_idx3", 64'(mutsel[31:24]), 64'h44);

    // Random traffic against the model.
    begin
      bit pend;
      pend = 0;
      for (int i = 0; i < 600; i++) begin
        if (!pend) begin
          req($urandom_range(0, 1), $urandom_range(0, 3),
              $urandom_range(0, 255), $urandom_range(0, 4));
        end
        clear = '0;
        for (int c = 0; c < NCH; c++)
          clear[c] = ($urandom_range(0, 15) == 0);
        rst_n = ($urandom_range(0, 99) != 0);
        golden = $urandom;
        mutant = golden;
        cmp_valid = 4'($urandom);
        for (int c = 0; c < NCH; c++)
          if ($urandom_range(0, 2) == 0)
            mutant[c*CW +: CW] = 8'($urandom);
        pend = cfg_valid && !exp_ready();
        tick();
      end
    end
    rst_n = 1;
    req(0, 0, 0, 0);

    // Reset during ACTIVE on channel 1.
    clear = 4'hF;
    tick();
    clear = '0;
    req(1, 1, 8'h11, 0);
    tick();
    req(0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      cmp(1, 1, 1);
      tick();
    end
    cmp(1, 0, 0);
    #1;
    chk("pre_rst_act1", 64'(active[1]), 64'h1);
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    #1;
    chk("rst_mutsel2", 64'(mutsel), 64'h0);
    chk("rst_det2", 64'(detected), 64'h0);
    chk("rst_div2", 64'(div_cnt), 64'h0);
    chk("rst_act2", 64'(active), 64'h0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
